draw_request_arbiter: RTL and testbench

- Shares one DrawMif sprite-drawing engine between NUM_REQ independent requesters, e.g. game-object and UI logic, using round-robin arbitration.
- Latches the granted requester's origin and MIF id, issues a single draw pulse to DrawMif, and tracks DrawMif's ready line to detect completion.
- Reports acceptance and completion back to each requester.
- Sits between application logic and DrawMif, which in turn drives the LT24 display.

---
 rtl/draw_request_arbiter.sv | 163 ++++++++++++++++
 tb/tb_draw_request_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_request_arbiter.sv
// rtl/draw_request_arbiter.sv - round-robin arbiter sharing one DrawMif engine between requesters
module draw_request_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     reqValid,
  input  logic [16*NUM_REQ-1:0]  reqX,
  input  logic [16*NUM_REQ-1:0]  reqY,
  input  logic [8*NUM_REQ-1:0]   reqMif,
  output logic [NUM_REQ-1:0]     reqAck,
  output logic [NUM_REQ-1:0]     reqDone,
  output logic                   busy,
  output logic [2:0]             grantId,
  output logic [15:0]            xOrigin,
  output logic [15:0]            yOrigin,
  output logic [7:0]             mifId,
  output logic                   draw,
  input  logic                   ready
);

  localparam int CNT_W = $clog2(START_TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ISSUE      = 2'd1;
  localparam logic [1:0] ST_WAIT_START = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         grant_q, grant_d;
  logic [15:0]        x_q, x_d;
  logic [15:0]        y_q, y_d;
  logic [7:0]         mif_q, mif_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic               found;
  logic [2:0]         pick;
  logic [15:0]        pick_x;
  logic [15:0]        pick_y;
  logic [7:0]         pick_mif;
  logic [NUM_REQ-1:0] grant_mask;

  // Round-robin pick: lowest active requester at or above the pointer, else lowest overall
  always_comb begin
    logic       hi_found;
    logic [2:0] hi_pick;
    logic [2:0] any_pick;
    hi_found = 1'b0;
    hi_pick  = 3'd0;
    any_pick = 3'd0;
    found    = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (reqValid[i]) begin
        found    = 1'b1;
        any_pick = 3'(i);
        if (3'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_pick  = 3'(i);
        end
      end
    end
    pick = hi_found ? hi_pick : any_pick;
  end

  // Mux the picked requester's draw parameters and decode the current grant
  always_comb begin
    pick_x     = 16'd0;
    pick_y     = 16'd0;
    pick_mif   = 8'd0;
    grant_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (3'(i) == pick) begin
        pick_x   = reqX[16*i +: 16];
        pick_y   = reqY[16*i +: 16];
        pick_mif = reqMif[8*i +: 8];
      end
      grant_mask[i] = (3'(i) == grant_q);
    end
  end

  // Next-state logic: grant, single draw pulse, then follow DrawMif's ready line to completion
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    x_d     = x_q;
    y_d     = y_q;
    mif_d   = mif_q;
    cnt_d   = cnt_q;
    done_d  = '0;
    case (state_q)
      ST_IDLE: begin
        // ready low also covers DrawMif still initialising or finishing a pre-reset draw
        if (ready && found) begin
          state_d = ST_ISSUE;
          grant_d = pick;
          x_d     = pick_x;
          y_d     = pick_y;
          mif_d   = pick_mif;
        end
      end
      ST_ISSUE: begin
        ptr_d   = (grant_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
        cnt_d   = '0;
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (!ready) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          // DrawMif never went busy: treat as a zero-work draw
          state_d = ST_IDLE;
          done_d  = grant_mask;
        end else begin
          cnt_d = (cnt_q == CNT_W'(START_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (ready) begin
          state_d = ST_IDLE;
          done_d  = grant_mask;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset does not touch DrawMif, it only forgets the grant
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      grant_q <= 3'd0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      mif_q   <= 8'd0;
      cnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mif_q   <= mif_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign draw    = (state_q == ST_ISSUE);
  assign reqAck  = draw ? grant_mask : '0;
  assign reqDone = done_q;
  assign busy    = (state_q != ST_IDLE);
  assign grantId = grant_q;
  assign xOrigin = x_q;
  assign yOrigin = y_q;
  assign mifId   = mif_q;

endmodule

// File: tb/tb_draw_request_arbiter.sv
// tb/tb_draw_request_arbiter.sv - directed self-checking bench for draw_request_arbiter
module tb_draw_request_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  reqValid;
  logic [63:0] reqX;
  logic [63:0] reqY;
  logic [31:0] reqMif;
  logic [3:0]  reqAck;
  logic [3:0]  reqDone;
  logic        busy;
  logic [2:0]  grantId;
  logic [15:0] xOrigin;
  logic [15:0] yOrigin;
  logic [7:0]  mifId;
  logic        draw;
  logic        ready;

  logic        ready_force;
  int          busy_len  = 0;
  int          model_cnt = 0;

  int errors = 0;
  int checks = 0;

  always #10 clock = ~clock;

  draw_request_arbiter #(.NUM_REQ(4), .START_TIMEOUT(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .reqValid (reqValid),
    .reqX     (reqX),
    .reqY     (reqY),
    .reqMif   (reqMif),
    .reqAck   (reqAck),
    .reqDone  (reqDone),
    .busy     (busy),
    .grantId  (grantId),
    .xOrigin  (xOrigin),
    .yOrigin  (yOrigin),
    .mifId    (mifId),
    .draw     (draw),
    .ready    (ready)
  );

  // DrawMif stand-in: a draw pulse makes it busy (ready low) for busy_len cycles
  always @(posedge clock) begin
    if (model_cnt > 0) model_cnt <= model_cnt - 1;
    else if (draw && busy_len > 0) model_cnt <= busy_len;
  end

  assign ready = ready_force && (model_cnt == 0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y, input logic [7:0] m);
    reqX[16*i +: 16] = x;
    reqY[16*i +: 16] = y;
    reqMif[8*i +: 8] = m;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (reqAck == 4'd0 && n < 300) begin
      step();
      n++;
    end
    check("ack_seen", reqAck != 4'd0, 1);
  endtask

  task automatic wait_done(output int n, output bit ack_during);
    n = 0;
    ack_during = 1'b0;
    do begin
      step();
      n++;
      if (reqAck != 4'd0) ack_during = 1'b1;
    end while (reqDone == 4'd0 && n < 300);
    check("done_seen", reqDone != 4'd0, 1);
  endtask

  initial begin
    int  n;
    int  rise_n;
    int  done_n;
    bit  ov;
    bit  bad;
    bit  prev_ready;
    int  exp_gid;

    reset       = 1'b0;
    reqValid    = 4'b1111;
    ready_force = 1'b1;
    reqX        = '0;
    reqY        = '0;
    reqMif      = '0;
    for (int i = 0; i < 4; i++) set_req(i, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 8'h10 + 8'(i));

    // Reset held with all requests pending
    repeat (5) step();
    check("rst_ctrl", {draw, reqAck, reqDone, busy, grantId}, 0);
    check("rst_data", {xOrigin, yOrigin, mifId}, 0);

    // Release: requester 0 granted, draw one cycle later
    reset = 1'b1;
    step();
    check("t1_draw", draw, 1);
    check("t1_ack", reqAck, 4'b0001);
    check("t1_gid", grantId, 0);
    check("t1_busy", busy, 1);
    check("t1_data", {xOrigin, yOrigin, mifId}, {16'h0100, 16'h0200, 8'h10});
    step();
    check("t1_pulse", {draw, reqAck}, 0);

    // DrawMif ignores the draw: timeout completion after 16 WAIT_START cycles
    wait_done(n, ov);
    check("t4_timeout_cycles", n, 16);
    check("t4_done", reqDone, 4'b0001);
    check("t4_busy", busy, 0);
    wait_ack(n);
    check("t4_next_gap", n, 1);
    check("t4_next_ack", reqAck, 4'b0010);
    check("t4_next_data", {xOrigin, yOrigin, mifId}, {16'h0101, 16'h0201, 8'h11});

    // Continuous requests: round-robin continues 2,3,0
    busy_len = 3;
    for (int g = 0; g < 3; g++) begin
      exp_gid = (g + 2) % 4;
      wait_done(n, ov);
      check("rr_no_overlap", ov, 0);
      wait_ack(n);
      check("rr_gap", n, 1);
      check("rr_ack", reqAck, 4'd1 << exp_gid);
      check("rr_gid", grantId, exp_gid);
      check("rr_draw", draw, 1);
    end
    reqValid = 4'b0000;
    wait_done(n, ov);

    // Single requester 2, DrawMif busy for 20 cycles
    set_req(2, 16'd100, 16'd50, 8'd3);
    busy_len = 20;
    reqValid = 4'b0100;
    wait_ack(n);
    check("t2_ack", reqAck, 4'b0100);
    check("t2_data", {xOrigin, yOrigin, mifId}, {16'd100, 16'd50, 8'd3});
    reqValid = 4'b0000;
    set_req(2, 16'hDEAD, 16'hBEEF, 8'hAA);
    bad    = 1'b0;
    rise_n = 0;
    done_n = 0;
    for (int k = 1; k <= 60 && done_n == 0; k++) begin
      step();
      if ({xOrigin, yOrigin, mifId} != {16'd100, 16'd50, 8'd3}) bad = 1'b1;
      if (ready && rise_n == 0) rise_n = k;
      if (reqDone != 4'd0) begin
        done_n = k;
        check("t2_done", reqDone, 4'b0100);
        check("t2_busy", busy, 0);
      end
    end
    check("t2_stable", bad, 0);
    check("t2_ready_rise", rise_n, 21);
    check("t2_done_cycle", done_n, 22);
    step();
    check("t2_done_pulse", reqDone, 0);

    // DrawMif still initialising: no grant for 200 cycles, then grant on next cycle
    reset       = 1'b0;
    busy_len    = 0;
    ready_force = 1'b0;
    reqValid    = 4'b0010;
    repeat (2) step();
    reset = 1'b1;
    bad   = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (draw || reqAck != 4'd0) bad = 1'b1;
    end
    check("t5_no_grant", bad, 0);
    ready_force = 1'b1;
    busy_len    = 30;
    step();
    check("t5_ack", reqAck, 4'b0010);
    check("t5_gid", grantId, 1);
    check("t5_draw", draw, 1);
    reqValid = 4'b0000;

    // Reset during WAIT_DONE: outputs clear, no reqDone, no grant until DrawMif ready
    repeat (3) step();
    check("t6_busy_before", busy, 1);
    reset = 1'b0;
    step();
    check("t6_rst_ctrl", {draw, reqAck, reqDone, busy, grantId}, 0);
    check("t6_rst_data", {xOrigin, yOrigin, mifId}, 0);
    reset      = 1'b1;
    reqValid   = 4'b0001;
    prev_ready = ready;
    bad        = 1'b0;
    n          = 0;
    for (int k = 1; k <= 80 && n == 0; k++) begin
      step();
      if (reqDone != 4'd0) bad = 1'b1;
      if (reqAck != 4'd0) begin
        n = k;
        check("t6_ready_before_grant", prev_ready, 1);
        check("t6_ack", reqAck, 4'b0001);
      end
      prev_ready = ready;
    end
    check("t6_no_done", bad, 0);
    check("t6_ack_cycle", n, 28);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
